// File: rtl/n64_vtiming_probe.sv
// N64 video timing probe: derives the packed demux parameter word and interlace status from nDSYNC and the sync bits.
// Optional VINFO_STABLE_FILTER_EN: vmode/interlaced_o commit only after two consecutive field ends agree.
`timescale 1ns/1ps
module n64_vtiming_probe #(
  parameter int unsigned LINECNT_W       = 10,
  parameter int unsigned PAL_LINE_THRESH = 300
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       nDSYNC,
  input  logic [3:0] D_i,
  input  logic [1:0] deblurcfg_i,
  input  logic       n15bit_mode_i,
  output logic [4:0] demuxparams_o,
  output logic       interlaced_o
);

  localparam logic [LINECNT_W-1:0] LINECNT_MAX = '1;
  localparam logic [LINECNT_W-1:0] PAL_THRESH  = LINECNT_W'(PAL_LINE_THRESH);

  // Bus bit positions inside D_i / sync_q
  localparam int unsigned VS_BIT = 3;
  localparam int unsigned HS_BIT = 1;

  logic [1:0]           data_cnt_q,   data_cnt_d;
  logic [3:0]           sync_q,       sync_d;
  logic [LINECNT_W-1:0] linecnt_q,    linecnt_d;
  logic                 prev_par_q,   prev_par_d;
  logic                 par_valid_q,  par_valid_d;
  logic                 vmode_q,      vmode_d;
  logic                 interlaced_q, interlaced_d;
  logic                 ndo_deblur_q, ndo_deblur_d;
  logic                 n16bit_q,     n16bit_d;
`ifdef VINFO_STABLE_FILTER_EN
  // A pending flag means the previous field end wanted the opposite of the committed value.
  logic                 vm_pend_q,    vm_pend_d;
  logic                 il_pend_q,    il_pend_d;
`endif

  logic hs_fall;
  logic vs_fall;
  logic vmode_new;
  logic il_new;

  // Clamp and composite sync are captured with the rest of the bus but do not drive timing.
  logic unused_sync;
  assign unused_sync = ^{sync_q[2], sync_q[0]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    data_cnt_d   = nDSYNC ? data_cnt_q + 2'd1 : 2'd1;
    sync_d       = nDSYNC ? sync_q : D_i;
    linecnt_d    = linecnt_q;
    prev_par_d   = prev_par_q;
    par_valid_d  = par_valid_q;
    vmode_d      = vmode_q;
    interlaced_d = interlaced_q;
    ndo_deblur_d = ndo_deblur_q;
    n16bit_d     = n16bit_q;
`ifdef VINFO_STABLE_FILTER_EN
    vm_pend_d    = vm_pend_q;
    il_pend_d    = il_pend_q;
`endif

    hs_fall   = ~nDSYNC & sync_q[HS_BIT] & ~D_i[HS_BIT];
    vs_fall   = ~nDSYNC & sync_q[VS_BIT] & ~D_i[VS_BIT];
    vmode_new = (linecnt_q > PAL_THRESH);
    il_new    = par_valid_q & (linecnt_q[0] != prev_par_q);

    if (vs_fall) begin
      // Field end wins over a coincident line edge: that line is not counted.
      linecnt_d   = '0;
      prev_par_d  = linecnt_q[0];
      par_valid_d = 1'b1;
      n16bit_d    = ~n15bit_mode_i;
`ifdef VINFO_STABLE_FILTER_EN
      if (vmode_new == vmode_q) begin
        vm_pend_d = 1'b0;
      end else if (vm_pend_q) begin
        vmode_d   = vmode_new;
        vm_pend_d = 1'b0;
      end else begin
        vm_pend_d = 1'b1;
      end
      if (il_new == interlaced_q) begin
        il_pend_d = 1'b0;
      end else if (il_pend_q) begin
        interlaced_d = il_new;
        il_pend_d    = 1'b0;
      end else begin
        il_pend_d = 1'b1;
      end
`else
      vmode_d      = vmode_new;
      interlaced_d = il_new;
`endif
      // Auto mode deblurs only progressive video, using the value committed this cycle.
      if (deblurcfg_i[1])      ndo_deblur_d = 1'b0;
      else if (deblurcfg_i[0]) ndo_deblur_d = 1'b1;
      else                     ndo_deblur_d = interlaced_d;
    end else if (hs_fall && (linecnt_q != LINECNT_MAX)) begin
      linecnt_d = linecnt_q + LINECNT_W'(1);
    end
  end

  always_ff @(posedge VCLK) begin
    // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
    if (RST) begin
      data_cnt_q   <= 2'd0;
      sync_q       <= 4'hF;
      linecnt_q    <= '0;
      prev_par_q   <= 1'b0;
      par_valid_q  <= 1'b0;
      vmode_q      <= 1'b0;
      interlaced_q <= 1'b0;
      ndo_deblur_q <= 1'b1;
      n16bit_q     <= 1'b1;
`ifdef VINFO_STABLE_FILTER_EN
      vm_pend_q    <= 1'b0;
      il_pend_q    <= 1'b0;
`endif
    end else begin
      data_cnt_q   <= data_cnt_d;
      sync_q       <= sync_d;
      linecnt_q    <= linecnt_d;
      prev_par_q   <= prev_par_d;
      par_valid_q  <= par_valid_d;
      vmode_q      <= vmode_d;
      interlaced_q <= interlaced_d;
      ndo_deblur_q <= ndo_deblur_d;
      n16bit_q     <= n16bit_d;
`ifdef VINFO_STABLE_FILTER_EN
      vm_pend_q    <= vm_pend_d;
      il_pend_q    <= il_pend_d;
`endif
    end
  end

  assign demuxparams_o = {data_cnt_q, vmode_q, ndo_deblur_q, n16bit_q};
  assign interlaced_o  = interlaced_q;

endmodule

// File: tb/tb_n64_vtiming_probe.sv
// Directed self-checking bench for n64_vtiming_probe: reset, data_cnt phasing, field timing, config latching, saturation.
`timescale 1ns/1ps
module tb_n64_vtiming_probe;

  logic       VCLK = 1'b0;
  logic       RST;
  logic       nDSYNC;
  logic [3:0] D_i;
  logic [1:0] deblurcfg_i;
  logic       n15bit_mode_i;
  logic [4:0] demuxparams_o;
  logic       interlaced_o;

  int n_checks = 0;
  int n_errors = 0;

  n64_vtiming_probe dut (
    .VCLK          (VCLK),
    .RST           (RST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .deblurcfg_i   (deblurcfg_i),
    .n15bit_mode_i (n15bit_mode_i),
    .demuxparams_o (demuxparams_o),
    .interlaced_o  (interlaced_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  // One 4-cycle pixel frame: sync nibble in the nDSYNC-low cycle, junk on the data cycles.
  task automatic frame(input logic [3:0] d);
    nDSYNC = 1'b0; D_i = d; tick();
    nDSYNC = 1'b1; D_i = 4'h0;
    repeat (3) tick();
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      frame(4'b1100);
      frame(4'b1111);
    end
  endtask

  task automatic field_end();
    frame(4'b0111);
    frame(4'b1111);
  endtask

  initial begin
    RST = 1'b1; nDSYNC = 1'b1; D_i = 4'hF; deblurcfg_i = 2'b00; n15bit_mode_i = 1'b0;
    repeat (3) tick();
    check("reset_word", demuxparams_o, 5'b00011);
    check("reset_il", interlaced_o, 1'b0);
    RST = 1'b0;

    // data_cnt phasing
    for (int f = 0; f < 2; f++) begin
      nDSYNC = 1'b0; tick();
      check("dcnt_r", demuxparams_o[4:3], 2'd1);
      nDSYNC = 1'b1;
      tick(); check("dcnt_g", demuxparams_o[4:3], 2'd2);
      tick(); check("dcnt_b", demuxparams_o[4:3], 2'd3);
      tick(); check("dcnt_idx", demuxparams_o[4:3], 2'd0);
    end
    nDSYNC = 1'b0; tick(); check("early_a", demuxparams_o[4:3], 2'd1);
    nDSYNC = 1'b1; tick(); check("early_b", demuxparams_o[4:3], 2'd2);
    nDSYNC = 1'b0; tick(); check("early_resync", demuxparams_o[4:3], 2'd1);
    nDSYNC = 1'b1; tick(); tick();

    // Progressive 263-line fields
    lines(263); field_end();
    check("prog1_word", demuxparams_o, 5'b00001);
    lines(263);
    frame(4'b0100);  // vsync and hsync fall together
    check("prog2_word", demuxparams_o, 5'b00001);
    check("prog2_il", interlaced_o, 1'b0);
    check("coincident_hs_not_counted", dut.linecnt_q, 10'd0);
    frame(4'b1111);

    // Alternating 312/313 fields
    lines(312); field_end();
`ifdef VINFO_STABLE_FILTER_EN
    check("pal1_word", demuxparams_o, 5'b00001);
    check("pal1_il", interlaced_o, 1'b0);
`else
    check("pal1_word", demuxparams_o, 5'b00111);
    check("pal1_il", interlaced_o, 1'b1);
`endif
    lines(313); field_end();
    check("pal2_word", demuxparams_o, 5'b00111);
    check("pal2_il", interlaced_o, 1'b1);
    lines(312); field_end();
    lines(313); field_end();
    check("pal4_word", demuxparams_o, 5'b00111);
    check("pal4_il", interlaced_o, 1'b1);

    // Mid-field config changes latch only at the field end
    lines(150);
    deblurcfg_i = 2'b01;
    lines(50);
    deblurcfg_i = 2'b10; n15bit_mode_i = 1'b1;
    lines(5);
    check("cfg_midfield", demuxparams_o[2:0], 3'b111);
    lines(107);
    check("cfg_before_vs", demuxparams_o[2:0], 3'b111);
    nDSYNC = 1'b0; D_i = 4'b0111; tick();
    check("cfg_after_vs_word", demuxparams_o, 5'b01100);
    check("cfg_after_vs_il", interlaced_o, 1'b1);
    nDSYNC = 1'b1; D_i = 4'h0; repeat (3) tick();
    frame(4'b1111);

    // Reset in the middle of traffic
    lines(20);
    RST = 1'b1;
    nDSYNC = 1'b0; D_i = 4'b1100; tick();
    nDSYNC = 1'b1; D_i = 4'h0; tick(); tick();
    check("midrst_word", demuxparams_o, 5'b00011);
    check("midrst_il", interlaced_o, 1'b0);
    check("midrst_linecnt", dut.linecnt_q, 10'd0);
    RST = 1'b0; deblurcfg_i = 2'b00; n15bit_mode_i = 1'b0;
    tick();

    // Saturating line counter
    lines(1100);
    check("sat_linecnt", dut.linecnt_q, 10'd1023);
    field_end();
`ifdef VINFO_STABLE_FILTER_EN
    check("sat1_word", demuxparams_o, 5'b00001);
    lines(1100); field_end();
`endif
    check("sat_vmode_word", demuxparams_o, 5'b00101);
    check("sat_il", interlaced_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
